// File: rtl/sp_share_arbiter.sv
// sp_share_arbiter
//   Round-robin arbiter and load sequencer for one shared WIDTH-bit holding
//   register built from enable flops. One requester owns the register per
//   cycle. Its data is steered onto the register D inputs, and the common
//   load enable SP is pulsed for that cycle.
//
//   Optional owner lock: define SPARB_LOCK_EN. A locked owner may keep the
//   grant for up to MAXLOCK consecutive cycles.
//
// Ports
//   CK     rising-edge clock
//   CD     asynchronous active-high clear
//   REQ    per-requester request level
//   LOCK   per-requester lock request (only used with SPARB_LOCK_EN)
//   D      requester i data at [i*WIDTH +: WIDTH]
//   GNT    registered one-hot grant
//   ACK    equals GNT; high in the cycle whose closing edge loads Q
//   SP     registered shared load enable (OR of GNT)
//   OWNER  index of the current or last owner
//   BUSY   high while in GRANT
//   Q      shared register contents

// Per-requester eligibility. The current owner is masked so that it cannot
// win twice in a row, unless the lock continuation keeps it.
module sparb_lane (
  input  logic req,
  input  logic own,
  input  logic keep,
  output logic elig
);
  assign elig = req & (~own | keep);
endmodule

module sp_share_arbiter #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 8,
  parameter int MAXLOCK = 16
) (
  input  logic                  CK,
  input  logic                  CD,
  input  logic [NREQ-1:0]       REQ,
  input  logic [NREQ-1:0]       LOCK,
  input  logic [NREQ*WIDTH-1:0] D,
  output logic [NREQ-1:0]       GNT,
  output logic [NREQ-1:0]       ACK,
  output logic                  SP,
  output logic [2:0]            OWNER,
  output logic                  BUSY,
  output logic [WIDTH-1:0]      Q
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  typedef struct packed {
    state_t          state;
    logic [2:0]      owner;
    logic [NREQ-1:0] gnt;
  } dec_t;

  state_t              state;
  logic [2:0]          ptr;
  logic [NREQ-1:0]     elig;
  logic                lock_cont;
  logic [7:0][WIDTH-1:0] d_x;
  dec_t                nxt;

  // search scratch
  logic [2:0] base;
  logic [3:0] sum;
  logic [2:0] win;
  logic       found;
  logic [7:0] elig_x;

  // GNT is exactly the one-hot of OWNER while in GRANT, and is zero in IDLE,
  // so it doubles as the owner mask.
  sparb_lane u_lane [NREQ-1:0] (
    .req  (REQ),
    .own  (GNT),
    .keep (lock_cont),
    .elig (elig)
  );

  // Data steering, padded to 8 entries so OWNER can index it directly.
  for (genvar i = 0; i < 8; i++) begin : g_dx
    if (i < NREQ) begin : g_real
      assign d_x[i] = D[i*WIDTH +: WIDTH];
    end else begin : g_pad
      assign d_x[i] = '0;
    end
  end

`ifdef SPARB_LOCK_EN
  logic [7:0] lock_cnt;
  logic [7:0] req_x;
  logic [7:0] lock_x;

  assign req_x     = 8'(REQ);
  assign lock_x    = 8'(LOCK);
  assign lock_cont = (state == GRANT) && req_x[OWNER] && lock_x[OWNER] &&
                     (lock_cnt < 8'(MAXLOCK - 1));

  // Counts re-grants to the same owner. Any other outcome is an owner
  // change or a return to IDLE, both of which clear it.
  always_ff @(posedge CK or posedge CD) begin
    if (CD)             lock_cnt <= '0;
    else if (lock_cont) lock_cnt <= lock_cnt + 8'd1;
    else                lock_cnt <= '0;
  end
`else
  logic unused_lock;
  assign lock_cont   = 1'b0;
  assign unused_lock = ^LOCK;
`endif

  // Winner search. In GRANT, the owner is about to become the last owner at
  // this edge, so the search starts just above it. In IDLE, it starts above
  // the stored pointer.
  always_comb begin
    base   = (state == GRANT) ? OWNER : ptr;
    elig_x = 8'(elig);
    sum    = '0;
    win    = '0;
    found  = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      sum = {1'b0, base} + 4'(k);
      if (sum >= 4'(NREQ)) sum = sum - 4'(NREQ);
      if (!found && elig_x[sum[2:0]]) begin
        found = 1'b1;
        win   = sum[2:0];
      end
    end
  end

  // Next-state / next-output decision
  always_comb begin
    nxt.state = IDLE;
    nxt.owner = OWNER;
    nxt.gnt   = '0;
    if (found) begin
      nxt.state = GRANT;
      nxt.owner = lock_cont ? OWNER : win;
      for (int i = 0; i < NREQ; i++) nxt.gnt[i] = (nxt.owner == 3'(i));
    end
  end

  always_ff @(posedge CK or posedge CD) begin
    if (CD) begin
      state <= IDLE;
      GNT   <= '0;
      SP    <= 1'b0;
      OWNER <= '0;
      ptr   <= 3'(NREQ - 1);
      Q     <= '0;
    end else begin
      state <= nxt.state;
      GNT   <= nxt.gnt;
      SP    <= |nxt.gnt;
      OWNER <= nxt.owner;
      // SP high marks a grant cycle. Its closing edge captures the owner's
      // data and records that owner as the round-robin pointer.
      if (SP) begin
        Q   <= d_x[OWNER];
        ptr <= OWNER;
      end
    end
  end

  assign ACK  = GNT;
  assign BUSY = (state == GRANT);

endmodule

// File: tb/tb_sp_share_arbiter.sv
module tb_sp_share_arbiter;
  localparam int NREQ = 4, WIDTH = 8, MAXLOCK = 4;

  logic                  CK = 1'b0;
  logic                  CD = 1'b1;
  logic [NREQ-1:0]       REQ = '0;
  logic [NREQ-1:0]       LOCK = '0;
  logic [NREQ*WIDTH-1:0] D = '0;
  logic [NREQ-1:0]       GNT, ACK;
  logic                  SP, BUSY;
  logic [2:0]            OWNER;
  logic [WIDTH-1:0]      Q;

  int n_pass = 0, n_total = 0;
  bit done = 0;

  sp_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .MAXLOCK(MAXLOCK)) dut (
    .CK(CK), .CD(CD), .REQ(REQ), .LOCK(LOCK), .D(D),
    .GNT(GNT), .ACK(ACK), .SP(SP), .OWNER(OWNER), .BUSY(BUSY), .Q(Q)
  );

  always #5 CK = ~CK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference model: the owner is a number, the pointer is the last served
  // index, and the winner is found by scanning requesters in ring order.
  int  m_owner, m_ptr, m_cnt, m_win;
  bit  m_busy, m_cont;
  logic [NREQ-1:0]  m_elig;
  logic [WIDTH-1:0] m_q;

  always @(posedge CK or posedge CD) begin
    if (CD) begin
      m_busy = 0; m_owner = 0; m_ptr = NREQ - 1; m_q = '0; m_cnt = 0;
    end else begin
      m_elig = REQ;
      m_cont = 0;
      if (m_busy) begin
`ifdef SPARB_LOCK_EN
        m_cont = REQ[m_owner] && LOCK[m_owner] && (m_cnt < MAXLOCK - 1);
`endif
        if (!m_cont) m_elig[m_owner] = 1'b0;
        m_q   = D[m_owner*WIDTH +: WIDTH];
        m_ptr = m_owner;
      end
      m_win = -1;
      if (m_cont) m_win = m_owner;
      else
        for (int k = 1; k <= NREQ; k++)
          if (m_win < 0 && m_elig[(m_ptr + k) % NREQ]) m_win = (m_ptr + k) % NREQ;
      m_cnt = m_cont ? m_cnt + 1 : 0;
      if (m_win < 0) m_busy = 0;
      else begin m_busy = 1; m_owner = m_win; end
    end
  end

  always @(negedge CK) begin
    if (!done) begin
      check("m_gnt",   32'(GNT),   m_busy ? (32'd1 << m_owner) : 32'd0);
      check("m_ack",   32'(ACK),   m_busy ? (32'd1 << m_owner) : 32'd0);
      check("m_sp",    32'(SP),    32'(m_busy));
      check("m_busy",  32'(BUSY),  32'(m_busy));
      check("m_owner", 32'(OWNER), 32'(m_owner));
      check("m_q",     32'(Q),     32'(m_q));
    end
  end

  task automatic cyc();
    @(posedge CK); #1;
  endtask

  task automatic set_d(input int i, input logic [WIDTH-1:0] v);
    D[i*WIDTH +: WIDTH] = v;
  endtask

  int lock_exp[6];

  initial begin
`ifdef SPARB_LOCK_EN
    lock_exp = '{0, 0, 0, 0, 1, 0};
`else
    lock_exp = '{0, 1, 0, 1, 0, 1};
`endif
    // reset state
    cyc(); cyc();
    check("rst_gnt", 32'(GNT), 0); check("rst_sp", 32'(SP), 0);
    check("rst_busy", 32'(BUSY), 0); check("rst_owner", 32'(OWNER), 0);
    check("rst_q", 32'(Q), 0);
    CD = 1'b0;

    // contention: full round-robin with back-to-back grants
    for (int i = 0; i < NREQ; i++) set_d(i, WIDTH'(8'h10 + i));
    REQ = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      cyc();
      check("cont_owner", 32'(OWNER), 32'(i % 4));
      check("cont_gnt", 32'(GNT), 32'd1 << (i % 4));
      check("cont_busy", 32'(BUSY), 1);
      if (i > 0) check("cont_q", 32'(Q), 32'(8'h10 + (i - 1) % 4));
    end
    REQ = '0;
    cyc(); check("cont_end_q", 32'(Q), 32'h13); check("cont_end_busy", 32'(BUSY), 0);

    // pointer: last owner 3, REQ 1001 -> 0 then 3
    REQ = 4'b1001;
    cyc(); check("ptr_first", 32'(OWNER), 0);
    cyc(); check("ptr_second", 32'(OWNER), 3);
    REQ = '0;
    cyc(); check("ptr_idle", 32'(GNT), 0);

    // single request
    set_d(0, 8'h3C);
    REQ = 4'b0001;
    cyc(); check("single_gnt", 32'(GNT), 1); check("single_sp", 32'(SP), 1);
    REQ = '0;
    cyc(); check("single_sp_off", 32'(SP), 0); check("single_q", 32'(Q), 32'h3C);
    check("single_busy", 32'(BUSY), 0);
    cyc(); check("single_hold_q", 32'(Q), 32'h3C);

    // requester 2 holds REQ one cycle past ACK
    set_d(2, 8'h77);
    REQ = 4'b0100;
    cyc(); check("held_gnt", 32'(GNT), 32'b0100);
    cyc(); check("held_no_regrant", 32'(GNT), 0); check("held_q", 32'(Q), 32'h77);
    REQ = '0;
    cyc(); check("held_dropped", 32'(GNT), 0);
    REQ = 4'b0100;
    cyc(); check("held_reraise", 32'(GNT), 32'b0100);
    REQ = '0;
    cyc();

    // lock behaviour
    REQ = 4'b0011; LOCK = 4'b0001;
    for (int i = 0; i < 6; i++) begin
      cyc(); check("lock_owner", 32'(OWNER), 32'(lock_exp[i]));
    end
    REQ = '0; LOCK = '0;
    cyc();

    // asynchronous reset during a grant cycle
    set_d(0, 8'hA5);
    REQ = 4'b0001;
    cyc(); check("arst_pre_gnt", 32'(GNT), 1);
    REQ = '0;
    #2 CD = 1'b1;
    #1;
    check("arst_gnt", 32'(GNT), 0); check("arst_sp", 32'(SP), 0);
    check("arst_busy", 32'(BUSY), 0); check("arst_owner", 32'(OWNER), 0);
    check("arst_q", 32'(Q), 0);
    cyc(); check("arst_q_after_edge", 32'(Q), 0);
    CD = 1'b0;
    REQ = 4'b0011;
    cyc(); check("post_rst_owner", 32'(OWNER), 0); check("post_rst_gnt", 32'(GNT), 1);
    REQ = '0;
    cyc(); check("post_rst_q", 32'(Q), 32'hA5);
    cyc();

    done = 1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, expected finish before 100000");
    $fatal(1);
  end
endmodule
